// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants.
// Used by both the transmit serializer and the receive path.
`timescale 1ns/100ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: tick on the last cycle of a bit, pre_tick one cycle earlier.
// Cleared synchronously so bit periods align to the accept edge.
`timescale 1ns/100ps
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o     = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign pre_tick_o = (cnt_q == CW'(CLKS_PER_BIT - 2));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one byte per valid/ready handshake, LSB first, 8N1/8N2.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1 via PARITY_ODD).
`timescale 1ns/100ps
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       RsTx
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_serializer: illegal parameter combination");
  end

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] sreg_q;
  logic [2:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 rstx_q, ready_q, done_q;
  logic                 tick, pre_tick, accept, last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  assign accept    = tx_valid && ready_q;
  assign last_stop = (state_q == STOP) && (stop_cnt_q == 1'(STOP_BITS - 1));

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept || (state_q == IDLE)),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  // ready_q is only high in IDLE or on the last stop cycle, so an accept
  // takes priority over the per-state handling and covers both cases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      rstx_q     <= IDLE_LEVEL;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      if (accept) begin
        sreg_q    <= tx_data;
        bit_cnt_q <= '0;
        rstx_q    <= ~IDLE_LEVEL;
        state_q   <= START;
`ifdef UART_TX_PARITY_EN
        par_q     <= (^tx_data) ^ PARITY_ODD[0];
`endif
      end else begin
        case (state_q)
          IDLE: ready_q <= 1'b1;
          START: if (tick) begin
            rstx_q  <= sreg_q[0];
            state_q <= DATA;
          end
          DATA: if (tick) begin
            sreg_q     <= sreg_q >> 1;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            stop_cnt_q <= 1'b0;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              rstx_q  <= par_q;
              state_q <= PARITY;
`else
              rstx_q  <= IDLE_LEVEL;
              state_q <= STOP;
`endif
            end else begin
              rstx_q <= sreg_q[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: if (tick) begin
            rstx_q  <= IDLE_LEVEL;
            state_q <= STOP;
          end
`endif
          STOP: begin
            if (tick) begin
              if (last_stop) begin
                state_q <= IDLE;
                ready_q <= 1'b1;
              end else begin
                stop_cnt_q <= stop_cnt_q + 1'b1;
              end
            end else if (pre_tick && last_stop) begin
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign tx_busy  = (state_q != IDLE);
  assign RsTx     = rstx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer (default 8N1 build, CLKS_PER_BIT=32).
`timescale 1ns/100ps
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, RsTx;

  int n_cmp = 0;
  int n_bad = 0;

  logic cap_line [1:800];
  logic cap_done [1:800];
  logic cap_rdy  [1:800];
  logic cap_busy [1:800];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, d7..d0, start}; frame[0] goes out first
  } vec_t;
  vec_t vecs [6];

  uart_tx_serializer #(.CLKS_PER_BIT(32), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .RsTx     (RsTx)
  );

  always #1 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Cycle c is the one between accept edge + (c-1) and accept edge + c.
  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap_line[c] = RsTx;
      cap_done[c] = tx_done;
      cap_rdy[c]  = tx_ready;
      cap_busy[c] = tx_busy;
    end
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_ready_wait"}, tx_ready, 1'b1);
  endtask

  task automatic check_frame(input int base, input logic [9:0] fr, input string nm);
    for (int i = 0; i < 10; i++) begin
      int bad = 0;
      for (int c = base + 32*i + 1; c <= base + 32*i + 32; c++)
        if (cap_line[c] !== fr[i]) bad++;
      chk($sformatf("%s_bit%0d_badcycles", nm, i), bad, 0);
    end
  endtask

  // Expect done (and ready) only on cycles e1/e2, ready again from idle_from on.
  task automatic check_pulses(input int n, input int e1, input int e2, input int idle_from,
                              input string nm);
    int bd = 0, br = 0, bb = 0;
    for (int c = 1; c <= n; c++) begin
      logic pulse;
      pulse = (c == e1) || (c == e2);
      if (cap_done[c] !== pulse) bd++;
      if (cap_rdy[c] !== (pulse || c >= idle_from)) br++;
      if (cap_busy[c] !== (c < idle_from)) bb++;
    end
    chk({nm, "_done_badcycles"}, bd, 0);
    chk({nm, "_ready_badcycles"}, br, 0);
    chk({nm, "_busy_badcycles"}, bb, 0);
  endtask

  task automatic check_idle(input int lo, input int hi, input string nm);
    int bad = 0;
    for (int c = lo; c <= hi; c++)
      if (cap_line[c] !== 1'b1) bad++;
    chk({nm, "_idle_badcycles"}, bad, 0);
  endtask

  task automatic send_single(input logic [7:0] d, input logic [9:0] fr, input string nm);
    wait_ready(nm);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    fork
      capture(360);
      begin
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check_frame(0, fr, nm);
    check_pulses(360, 320, 0, 321, nm);
    check_idle(321, 360, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    vecs[0] = '{8'h01, 10'b1000000010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h5A, 10'b1010110100};
    vecs[5] = '{8'h80, 10'b1100000000};

    // Reset held 100 ns, valid activity during reset must not start anything.
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tx_valid = (c % 3 == 0);
      tx_data  = 8'h00;
      if (RsTx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("reset_hold_badcycles", bad, 0);
    tx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_RsTx", RsTx, 1'b1);
    chk("post_reset_ready", tx_ready, 1'b1);
    chk("post_reset_busy", tx_busy, 1'b0);
    chk("post_reset_done", tx_done, 1'b0);

    for (int v = 0; v < 6; v++)
      send_single(vecs[v].data, vecs[v].frame, $sformatf("vec%0d", v));

    // Back-to-back: valid held across the done cycle; data changes mid-frame are ignored.
    wait_ready("b2b");
    @(negedge clk);
    tx_data  = 8'h02;
    tx_valid = 1'b1;
    fork
      capture(700);
      begin
        repeat (4) @(negedge clk);
        tx_data = 8'h03;
        repeat (317) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check_frame(0, 10'b1000000100, "b2b_f0");
    check_frame(320, 10'b1000000110, "b2b_f1");
    check_pulses(700, 320, 640, 641, "b2b");
    check_idle(641, 700, "b2b");

    // Busy ignore: 0xFF offered mid-frame of 0x05.
    wait_ready("ign");
    @(negedge clk);
    tx_data  = 8'h05;
    tx_valid = 1'b1;
    fork
      capture(400);
      begin
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (99) @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    join
    check_frame(0, 10'b1000001010, "ign");
    check_pulses(400, 320, 0, 321, "ign");
    check_idle(321, 400, "ign");

    // Reset mid-frame while the line is low (data bit 2 of 0x0A).
    wait_ready("rstmid");
    @(negedge clk);
    tx_data  = 8'h0A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (99) @(negedge clk);
    chk("rstmid_line_before", RsTx, 1'b0);
    #0.3 rst = 1'b1;
    #0.2;
    chk("rstmid_RsTx_async", RsTx, 1'b1);
    chk("rstmid_busy_async", tx_busy, 1'b0);
    chk("rstmid_ready_async", tx_ready, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || RsTx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("rstmid_no_done_badcycles", bad, 0);
    send_single(8'h0A, 10'b1000010100, "rstmid_retx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
